hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_md_busy_counter.sv | 48 ++++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the CPU hazard controller.
//   - hz_state_e : hazard controller FSM states (RUN, MD_BUSY)
//   - MUL_LAT_DEF / DIV_LAT_DEF : default HI/LO unit occupancy in cycles
//   - REG_ZERO   : architectural $zero register index (never a real producer)
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the ID/EX observation signals and the stall/flush controls
//   exchanged between the pipeline and the hazard controller.
//   modport master : pipeline side (drives ID/EX fields, receives controls)
//   modport slave  : hazard controller side
//   Signals:
//     ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_mul, ID_is_div, ID_use_hilo
//     EX_rt, EX_MemtoReg, EX_RegWr, EX_taken
//     Load_use, pc_hold, ifid_hold, ifid_flush, md_busy, md_done
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_use_rs;
    logic       ID_use_rt;
    logic       ID_is_mul;
    logic       ID_is_div;
    logic       ID_use_hilo;

    logic [4:0] EX_rt;
    logic       EX_MemtoReg;
    logic       EX_RegWr;
    logic       EX_taken;

    logic       Load_use;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic       md_busy;
    logic       md_done;

    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_mul, ID_is_div, ID_use_hilo,
        output EX_rt, EX_MemtoReg, EX_RegWr, EX_taken,
        input  Load_use, pc_hold, ifid_hold, ifid_flush, md_busy, md_done
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_mul, ID_is_div, ID_use_hilo,
        input  EX_rt, EX_MemtoReg, EX_RegWr, EX_taken,
        output Load_use, pc_hold, ifid_hold, ifid_flush, md_busy, md_done
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// ---------------------------------------------------------------------------
// md_busy_counter
//   Occupancy counter for the multi-cycle HI/LO unit. Loads the remaining
//   busy cycles on issue, counts down while the controller is busy and
//   raises a one-cycle done pulse when the occupancy expires.
//   Ports:
//     clk      : CPU clock, state changes on the falling edge
//     rst_n    : asynchronous active-low reset
//     load     : mul/div issues on this edge
//     load_val : cycles of occupancy left after the issue edge
//     dec      : controller is in its busy state, count down
//     expire   : combinational, this edge ends the occupancy
//     done     : registered one-cycle pulse after the occupancy ends
// ---------------------------------------------------------------------------
module md_busy_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expire,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // The last busy edge is the one that takes the count from 1 to 0.
    assign expire = dec & (count == WIDTH'(1));

    // Count register plus the done pulse. A zero-length load never enters
    // the busy state, so it reports completion straight away.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= (load & (load_val == '0)) | expire;
            if (load) begin
                count <= load_val;
            end else if (dec && (count != '0)) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller beside the ID stage. Detects load-use
//   hazards against the load in EX, flushes IF/ID on taken branches and,
//   when HAZARD_MD_STALL_EN is defined, stalls HI/LO consumers while a
//   mult/div occupies the HI/LO unit.
//   Parameters: MUL_LAT, DIV_LAT (HI/LO occupancy in cycles)
//   Ports:
//     clk   : CPU clock, state updates on the falling edge
//     rst_n : asynchronous active-low reset
//     hz    : hazard_ctrl_if.slave (ID/EX fields in, stall/flush out)
//   Configuration macro: HAZARD_MD_STALL_EN
// ---------------------------------------------------------------------------
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    logic lu_hit;
    logic md_hit;

    // A load in EX whose destination is read by the instruction in ID.
    // $zero is never a real dependency.
    assign lu_hit = hz.EX_MemtoReg & hz.EX_RegWr & (hz.EX_rt != REG_ZERO) &
                    ((hz.ID_use_rs & (hz.ID_rs == hz.EX_rt)) |
                     (hz.ID_use_rt & (hz.ID_rt == hz.EX_rt)));

    // Output priority: a taken branch squashes everything younger, so it
    // flushes IF/ID and bubbles ID/EX without holding; otherwise any stall
    // freezes PC and IF/ID and bubbles ID/EX. Everything is quiet in reset.
    always_comb begin
        hz.Load_use   = 1'b0;
        hz.pc_hold    = 1'b0;
        hz.ifid_hold  = 1'b0;
        hz.ifid_flush = 1'b0;
        if (rst_n) begin
            if (hz.EX_taken) begin
                hz.ifid_flush = 1'b1;
                hz.Load_use   = 1'b1;
            end else if (lu_hit || md_hit) begin
                hz.Load_use  = 1'b1;
                hz.pc_hold   = 1'b1;
                hz.ifid_hold = 1'b1;
            end
        end
    end

`ifdef HAZARD_MD_STALL_EN

    localparam int              CW       = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0]   MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]   DIV_LOAD = CW'(DIV_LAT - 1);

    hz_state_e     state_q;
    hz_state_e     state_d;
    logic          issue;
    logic          expire;
    logic [CW-1:0] load_val;

    // Any HI/LO user (including another mul/div) waits while the unit is busy.
    assign md_hit = (state_q == MD_BUSY) &
                    (hz.ID_use_hilo | hz.ID_is_mul | hz.ID_is_div);

    // A mul/div only issues if it actually leaves ID this edge; a stalled or
    // squashed one must not start the unit.
    assign issue    = rst_n & (hz.ID_is_mul | hz.ID_is_div) &
                      ~hz.EX_taken & ~lu_hit & ~md_hit;
    assign load_val = hz.ID_is_div ? DIV_LOAD : MUL_LOAD;

    assign hz.md_busy = (state_q == MD_BUSY);

    // State register; falls on the same edge as the segment registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter busy on a non-trivial issue, leave when the counter
    // reports the final busy edge. Branches do not cancel a committed op.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (issue && (load_val != '0)) begin
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (expire) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    md_busy_counter #(
        .WIDTH (CW)
    ) u_md_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue),
        .load_val (load_val),
        .dec      (state_q == MD_BUSY),
        .expire   (expire),
        .done     (hz.md_done)
    );

`else

    logic unused_md;

    // Without HI/LO tracking the mul/div/hilo flags carry no hazard.
    assign md_hit     = 1'b0;
    assign hz.md_busy = 1'b0;
    assign hz.md_done = 1'b0;
    assign unused_md  = ^{hz.ID_use_hilo, hz.ID_is_mul, hz.ID_is_div,
                          (MUL_LAT != DIV_LAT)};

`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Directed scenarios followed by a
//   randomized run, all checked against a cycle-indexed reference model.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import cpu_pkg::*;

`ifdef HAZARD_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int MUL_L = MUL_LAT_DEF;
    localparam int DIV_L = DIV_LAT_DEF;

    logic clk = 1'b1;
    logic rst_n = 1'b0;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MUL_LAT (MUL_L),
        .DIV_LAT (DIV_L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the HI/LO unit is described by the edge index at
    // which its occupancy ends. Edges are counted from reset release.
    int edge_cnt = 0;
    bit issued = 1'b0;
    int free_edge = 0;
    bit last_issue = 1'b0;
    bit last_stall = 1'b0;
    bit last_busy = 1'b0;

    task automatic checkBit(input string tag, input string name, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s.%s observed=%b expected=%b", tag, name, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt,
                                 input logic mul, input logic div, input logic hilo,
                                 input logic [4:0] ert, input logic m2r, input logic rw,
                                 input logic tk);
        hif.ID_rs       = rs;
        hif.ID_rt       = rt;
        hif.ID_use_rs   = urs;
        hif.ID_use_rt   = urt;
        hif.ID_is_mul   = mul;
        hif.ID_is_div   = div;
        hif.ID_use_hilo = hilo;
        hif.EX_rt       = ert;
        hif.EX_MemtoReg = m2r;
        hif.EX_RegWr    = rw;
        hif.EX_taken    = tk;
    endtask

    task automatic checkOutput(input string tag);
        bit busy, done, lu, md, e_lu, e_ph, e_ih, e_fl;
        #1;
        if (!rst_n) issued = 1'b0;
        busy = MD_EN && issued && (edge_cnt < free_edge);
        done = MD_EN && issued && (edge_cnt == free_edge);
        lu = hif.EX_MemtoReg && hif.EX_RegWr && (hif.EX_rt != 5'd0) &&
             ((hif.ID_use_rs && hif.ID_rs == hif.EX_rt) ||
              (hif.ID_use_rt && hif.ID_rt == hif.EX_rt));
        md = busy && (hif.ID_use_hilo || hif.ID_is_mul || hif.ID_is_div);
        e_fl = rst_n && hif.EX_taken;
        e_lu = rst_n && (hif.EX_taken || lu || md);
        e_ph = rst_n && !hif.EX_taken && (lu || md);
        e_ih = e_ph;
        last_stall = e_ph;
        last_busy  = busy;
        last_issue = rst_n && MD_EN && (hif.ID_is_mul || hif.ID_is_div) && !hif.EX_taken && !lu && !md;
        checkBit(tag, "Load_use",   hif.Load_use,   e_lu);
        checkBit(tag, "pc_hold",    hif.pc_hold,    e_ph);
        checkBit(tag, "ifid_hold",  hif.ifid_hold,  e_ih);
        checkBit(tag, "ifid_flush", hif.ifid_flush, e_fl);
        checkBit(tag, "md_busy",    hif.md_busy,    busy);
        checkBit(tag, "md_done",    hif.md_done,    done);
    endtask

    task automatic advanceEdge();
        bit was_div;
        was_div = hif.ID_is_div;
        @(negedge clk);
        if (rst_n) begin
            edge_cnt++;
            if (last_issue) begin
                issued = 1'b1;
                free_edge = edge_cnt + (was_div ? DIV_L : MUL_L) - 1;
            end
        end else begin
            issued = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic doStep(input string tag);
        checkOutput(tag);
        advanceEdge();
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    int stall_cnt;
    int done_cnt;
    int done_at;

    initial begin
        // Reset: outputs forced quiet even with hazards on the inputs.
        applyStimulus(5'd8, 5'd8, 1, 1, 0, 0, 1, 5'd8, 1, 1, 1);
        @(posedge clk);
        doStep("reset");
        rst_n = 1'b1;
        idle();
        doStep("idle");

        // Load-use: one bubble, then the bubble in EX clears the hazard.
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 0, 0, 5'd8, 1, 1, 0);
        doStep("lu_hit");
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        doStep("lu_after");
        applyStimulus(5'd3, 5'd8, 0, 1, 0, 0, 0, 5'd8, 1, 1, 0);
        doStep("lu_rt");

        // Load-use to $zero never stalls.
        applyStimulus(5'd0, 5'd0, 1, 1, 0, 0, 0, 5'd0, 1, 1, 0);
        doStep("lu_zero");

        // Taken branch outranks load-use.
        applyStimulus(5'd8, 5'd0, 1, 0, 0, 0, 0, 5'd8, 1, 1, 1);
        doStep("prio");

        // mult then mflo.
        applyStimulus(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 0, 0);
        doStep("mult_issue");
        stall_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
            checkOutput("mflo");
            if (hif.pc_hold) stall_cnt++;
            if (hif.md_done) done_cnt++;
            advanceEdge();
            if (!last_stall && !last_busy) break;
        end
        checkInt("mult_stall_cycles", stall_cnt, MD_EN ? MUL_L - 1 : 0);
        checkInt("mult_done_pulses", done_cnt, MD_EN ? 1 : 0);

        // div, taken branch at edge N+5, count must survive.
        applyStimulus(5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd0, 0, 0, 0);
        doStep("div_issue");
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 0, 0, (i == 4));
            checkOutput("div_wait");
            if (hif.md_done && done_at < 0) done_at = i;
            advanceEdge();
            if (done_at >= 0) break;
        end
        checkInt("div_done_cycle", done_at, MD_EN ? DIV_L - 1 : -1);

        // Async reset in the middle of a div.
        applyStimulus(5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd0, 0, 0, 0);
        doStep("div2_issue");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
            doStep("div2_run");
        end
        rst_n = 1'b0;
        checkOutput("div2_reset");
        advanceEdge();
        rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
        doStep("mfhi_after_reset");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int op;
            op = $urandom_range(0, 15);
            rst_n = ($urandom_range(0, 149) != 0);
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          (op == 0), (op == 1), (op >= 2 && op <= 6),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0));
            doStep("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
